// File: rtl/pipe_ctrl_pkg.sv
// Pipeline-wide shared constants: stall encodings, exception codes.
// Imported by the pipeline control block and its helpers.
package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int EXC_CODE_WIDTH = 5;

  typedef enum logic [EXC_CODE_WIDTH-1:0] {
    EC_INT     = 5'h00,
    EC_SYSCALL = 5'h08,
    EC_BREAK   = 5'h09,
    EC_RI      = 5'h0a,
    EC_OV      = 5'h0c,
    EC_ERET    = 5'h1e,
    EC_NONE    = 5'h1f
  } exc_code_e;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] STALL_NONE =
    {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
  localparam logic [5:0] STALL_IF =
    {NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP, STOP};
  localparam logic [5:0] STALL_ID =
    {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX =
    {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM =
    {NOSTOP, STOP, STOP, STOP, STOP, STOP};

  // Deepest requesting stage freezes itself and everything upstream.
  function automatic logic [5:0] stall_vec(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    if (req_mem)
      return STALL_MEM;
    else if (req_ex)
      return STALL_EX;
    else if (req_id)
      return STALL_ID;
    else if (req_if)
      return STALL_IF;
    else
      return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: saturating count of back-to-back stalled cycles
// with a sticky lockup flag cleared only by reset.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  input  logic flush,
  output logic stall_timeout
);

  localparam int W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(STALL_TIMEOUT);

  logic [W-1:0] scnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt          <= '0;
      stall_timeout <= 1'b0;
    end else if (!stalled || flush) begin
      scnt <= '0;
    end else if (scnt != LIMIT) begin
      scnt <= scnt + 1'b1;
      if (scnt == LIMIT - 1'b1)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception flush/redirect, watchdog.
// Define PIPE_CTRL_PERF_EN to add stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES  = 1,
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stallreq_if,
  input  logic                      stallreq_id,
  input  logic                      stallreq_ex,
  input  logic                      stallreq_mem,
  input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic [31:0]               cp0_epc_i,
  output logic [5:0]                stall,
  output logic                      flush,
  output logic [31:0]               new_pc,
  output logic                      stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flush_count
`endif
);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_e;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state;
  logic [2:0]  fcnt;
  logic [31:0] pc_hold;
  logic [31:0] exc_pc;
  logic        in_flush;
  logic        exc_hit;
  logic        stalled;

  assign in_flush = (state == S_FLUSH);
  assign exc_hit  = !in_flush && (exc_code_i != EC_NONE);
  assign exc_pc   = (exc_code_i == EC_ERET) ? cp0_epc_i : EXC_VECTOR;
  assign flush    = exc_hit || in_flush;

  assign stall = flush ? STALL_NONE :
    stall_vec(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
  assign stalled = (stall != STALL_NONE);

  always_comb begin
    new_pc = ZERO_WORD;
    if (in_flush)
      new_pc = pc_hold;
    else if (exc_hit)
      new_pc = exc_pc;
  end

  // First flush cycle is combinational; the rest replay pc_hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      fcnt    <= 3'd0;
      pc_hold <= ZERO_WORD;
    end else begin
      unique case (state)
        S_RUN: begin
          if (exc_hit) begin
            pc_hold <= exc_pc;
            if (FLUSH_CYCLES > 1) begin
              state <= S_FLUSH;
              fcnt  <= FCNT_INIT;
            end
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt - 3'd1;
          if (fcnt == 3'd1)
            state <= S_RUN;
        end
      endcase
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stalled),
    .flush        (flush),
    .stall_timeout(stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_count  <= 32'd0;
    end else begin
      if (stalled)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (exc_hit)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues hand-computed
// expectations per cycle, a monitor pops and compares on negedge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] EPC = 32'h8000_1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_if = 1'b0;
  logic        req_id = 1'b0;
  logic        req_ex = 1'b0;
  logic        req_mem = 1'b0;
  logic [4:0]  exc_code = EC_NONE;
  logic [31:0] epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .EXC_VECTOR   (VEC),
    .STALL_TIMEOUT(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_if      (req_if),
    .stallreq_id      (req_id),
    .stallreq_ex      (req_ex),
    .stallreq_mem     (req_mem),
    .exc_code_i       (exc_code),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count)
`endif
  );

  // No new exception may arrive while a flush is in progress.
  always @(negedge clk)
    if (!rst && dut.in_flush)
      assert (exc_code == EC_NONE)
        else $error("exception code during flush");

  // req = {mem, ex, id, if}
  task automatic step(
    input logic [3:0]  req,
    input logic [4:0]  ec,
    input logic [31:0] e,
    input logic        r,
    input string       nm,
    input logic [5:0]  es,
    input logic        ef,
    input logic [31:0] ep,
    input logic        et
  );
    exp_t x;
    @(posedge clk);
    #1;
    {req_mem, req_ex, req_id, req_if} = req;
    exc_code = ec;
    epc      = e;
    rst      = r;
    x.name   = nm;
    x.stall  = es;
    x.flush  = ef;
    x.new_pc = ep;
    x.to     = et;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      vectors++;
      if (stall !== x.stall || flush !== x.flush ||
          new_pc !== x.new_pc || stall_timeout !== x.to) begin
        miscompares++;
        $display("FAIL %s: got stall=%b flush=%b pc=%h to=%b want stall=%b flush=%b pc=%h to=%b",
                 x.name, stall, flush, new_pc, stall_timeout,
                 x.stall, x.flush, x.new_pc, x.to);
      end
    end
  end

  initial begin
    step(4'b0000, EC_NONE, 0, 1, "reset0", 6'b000000, 0, 0, 0);
    step(4'b0000, EC_NONE, 0, 1, "reset1", 6'b000000, 0, 0, 0);
    step(4'b0000, EC_NONE, 0, 0, "idle", 6'b000000, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      step(4'b0100, EC_NONE, 0, 0, "ex_stall", 6'b001111, 0, 0, 0);
    step(4'b0000, EC_NONE, 0, 0, "ex_release", 6'b000000, 0, 0, 0);

    step(4'b1010, EC_NONE, 0, 0, "id_mem", 6'b011111, 0, 0, 0);
    step(4'b0001, EC_NONE, 0, 0, "if_only", 6'b000011, 0, 0, 0);
    step(4'b0010, EC_NONE, 0, 0, "id_only", 6'b000111, 0, 0, 0);
    step(4'b0101, EC_NONE, 0, 0, "ex_if", 6'b001111, 0, 0, 0);
    step(4'b0000, EC_NONE, 0, 0, "idle2", 6'b000000, 0, 0, 0);

    step(4'b1000, EC_SYSCALL, 0, 0, "sys_f0", 6'b000000, 1, VEC, 0);
    step(4'b1000, EC_NONE, 0, 0, "sys_f1", 6'b000000, 1, VEC, 0);
    step(4'b1000, EC_NONE, 0, 0, "sys_f2", 6'b000000, 1, VEC, 0);
    step(4'b1000, EC_NONE, 0, 0, "sys_done", 6'b011111, 0, 0, 0);
    step(4'b0000, EC_NONE, 0, 0, "idle3", 6'b000000, 0, 0, 0);

    step(4'b0000, EC_ERET, EPC, 0, "eret_f0", 6'b000000, 1, EPC, 0);
    step(4'b0000, EC_NONE, 32'hDEADBEEF, 0, "eret_f1", 6'b000000, 1, EPC, 0);
    step(4'b0000, EC_NONE, 32'h0BAD0BAD, 0, "eret_f2", 6'b000000, 1, EPC, 0);
    step(4'b0000, EC_OV, 32'h0BAD0BAD, 0, "ov_f0", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 0, "ov_f1", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 0, "ov_f2", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 0, "ov_done", 6'b000000, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      step(4'b0001, EC_NONE, 0, 0, "wdog_pre", 6'b000011, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step(4'b0001, EC_NONE, 0, 0, "wdog_hit", 6'b000011, 0, 0, 1);
    for (int i = 0; i < 2; i++)
      step(4'b0000, EC_NONE, 0, 0, "wdog_sticky", 6'b000000, 0, 0, 1);
    step(4'b0000, EC_NONE, 0, 1, "wdog_rst", 6'b000000, 0, 0, 1);
    step(4'b0000, EC_NONE, 0, 0, "wdog_clear", 6'b000000, 0, 0, 0);

    step(4'b0000, EC_SYSCALL, 0, 0, "rf_f0", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 1, "rf_rst", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 0, "rf_after", 6'b000000, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    vectors++;
    if (perf_flush_count !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_flush_count: got %0d want 0", perf_flush_count);
    end
`endif
    step(4'b0010, EC_NONE, 0, 0, "rf_run", 6'b000111, 0, 0, 0);

    step(4'b0000, EC_BREAK, 0, 1, "exc_in_rst", 6'b000000, 1, VEC, 0);
    step(4'b0000, EC_NONE, 0, 0, "after_rst_exc", 6'b000000, 0, 0, 0);
    step(4'b0100, EC_NONE, 0, 0, "final_ex", 6'b001111, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
